// File: rtl/cheriot_sim_pkg.sv
// Shared constants and bus request type for the CHERIoT simulation harness.
// Optional feature: DII_SIM_EN (see cheriot_sim_harness).
package cheriot_sim_pkg;

    localparam logic [31:0] MEM_BASE     = 32'h8000_0000;
    localparam logic [31:0] CONSOLE_BASE = 32'h8F00_0000;
    localparam logic [7:0]  CONSOLE_TX   = 8'h00;
    localparam logic [7:0]  CONSOLE_STOP = 8'h04;
    localparam logic [31:0] DII_NOP      = 32'h0000_0001;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/cheriot_bus_if.sv
// req/gnt/rvalid memory bus between the core (master) and harness memories (slave).
interface cheriot_bus_if;
    import cheriot_sim_pkg::*;

    logic        req;
    logic        gnt;
    bus_req_t    pkt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output pkt, input gnt, input rvalid, input rdata);
    modport slave  (input req, input pkt, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/cheriot_sim_ram.sv
// Single-port registered-read RAMs: byte-enabled data RAM (dram) and a
// read-only instruction variant (iram), both preloaded hierarchically by benches.
module cheriot_sim_ram
    import cheriot_sim_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [MEM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rvalid,
    output logic [31:0]       rdata
);

    logic [31:0] dram [0:2**MEM_AW-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rvalid <= 1'b0;
        else       rvalid <= en;
    end

    // Reads return the pre-write word; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (en) begin
            rdata <= dram[addr];
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) dram[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

module cheriot_sim_ram_ro
    import cheriot_sim_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en,
    input  logic [MEM_AW-1:0] addr,
    output logic              rvalid,
    output logic [31:0]       rdata
);

    logic [31:0] iram [0:2**MEM_AW-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rvalid <= 1'b0;
        else       rvalid <= en;
    end

    always_ff @(posedge clk_i) begin
        if (en) rdata <= iram[addr];
    end

endmodule

// File: rtl/cheriot_sim_harness.sv
// Simulation harness: instruction/data RAMs, console/stop device, end-of-sim handshake.
// Define DII_SIM_EN to serve instruction fetches from dii_insn_i instead of iram.
module cheriot_sim_harness
    import cheriot_sim_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         dii_insn_i,
    output logic [31:0]         dii_pc_o,
    output logic                dii_ack_o,
    output logic                uart_stop_sim_o,
    input  logic                end_sim_req_i,
    output logic                end_sim_ack_o,
    cheriot_bus_if.slave        instr_bus,
    cheriot_bus_if.slave        data_bus
);

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        return MEM_AW'((addr - MEM_BASE) >> 2);
    endfunction

    logic i_gnt, d_gnt;
    logic d_is_con, d_ram_en, d_con_wr;
    logic [7:0] d_con_off;
    logic con_vld_p1, stop_p1, end_ack_p1;
    logic [31:0] fetch_pc_p1;
    logic ram_rvalid, rom_rvalid, rom_en;
    logic [31:0] ram_rdata, rom_rdata;

    // Grants are withheld while shutdown is pending or reset is held.
    assign i_gnt = instr_bus.req & ~end_sim_req_i & ~rst_i;
    assign d_gnt = data_bus.req  & ~end_sim_req_i & ~rst_i;
    assign instr_bus.gnt = i_gnt;
    assign data_bus.gnt  = d_gnt;

    assign d_is_con  = data_bus.pkt.addr[31:8] == CONSOLE_BASE[31:8];
    assign d_con_off = data_bus.pkt.addr[7:0];
    assign d_ram_en  = d_gnt & ~d_is_con;
    assign d_con_wr  = d_gnt & d_is_con & data_bus.pkt.we;

    cheriot_sim_ram #(.MEM_AW(MEM_AW)) u_data_mem (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en     (d_ram_en),
        .we     (data_bus.pkt.we),
        .be     (data_bus.pkt.be),
        .addr   (word_idx(data_bus.pkt.addr)),
        .wdata  (data_bus.pkt.wdata),
        .rvalid (ram_rvalid),
        .rdata  (ram_rdata)
    );

    cheriot_sim_ram_ro #(.MEM_AW(MEM_AW)) u_instr_mem (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en     (rom_en),
        .addr   (word_idx(instr_bus.pkt.addr)),
        .rvalid (rom_rvalid),
        .rdata  (rom_rdata)
    );

    assign data_bus.rvalid = ram_rvalid | con_vld_p1;
    assign data_bus.rdata  = con_vld_p1 ? 32'h0 : ram_rdata;

    // Stage p1: console response, sticky stop/ack flags, last fetch address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            con_vld_p1  <= 1'b0;
            stop_p1     <= 1'b0;
            end_ack_p1  <= 1'b0;
            fetch_pc_p1 <= 32'h0;
        end else begin
            con_vld_p1 <= d_gnt & d_is_con;
            if (d_con_wr && d_con_off == CONSOLE_STOP) stop_p1 <= 1'b1;
            // A response granted before this edge completes now; nothing new can be granted.
            if (end_sim_req_i && !(i_gnt || d_gnt)) end_ack_p1 <= 1'b1;
            if (instr_bus.req) fetch_pc_p1 <= instr_bus.pkt.addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (d_con_wr && d_con_off == CONSOLE_TX) $write("%c", data_bus.pkt.wdata[7:0]);
    end

    assign uart_stop_sim_o = stop_p1;
    assign end_sim_ack_o   = end_ack_p1;
    assign dii_pc_o        = (instr_bus.req && !rst_i) ? instr_bus.pkt.addr : fetch_pc_p1;

`ifdef DII_SIM_EN
    logic        dii_vld_p1;
    logic [31:0] dii_insn_p1;
    logic        unused_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) dii_vld_p1 <= 1'b0;
        else       dii_vld_p1 <= i_gnt;
    end

    always_ff @(posedge clk_i) begin
        if (i_gnt) dii_insn_p1 <= dii_insn_i;
    end

    assign rom_en           = 1'b0;
    assign dii_ack_o        = i_gnt;
    assign instr_bus.rvalid = dii_vld_p1;
    assign instr_bus.rdata  = dii_vld_p1 ? dii_insn_p1 : DII_NOP;
    assign unused_ok = ^{rom_rvalid, rom_rdata, instr_bus.pkt.we, instr_bus.pkt.be,
                         instr_bus.pkt.wdata};
`else
    logic unused_ok;

    assign rom_en           = i_gnt;
    assign dii_ack_o        = 1'b0;
    assign instr_bus.rvalid = rom_rvalid;
    assign instr_bus.rdata  = rom_rdata;
    assign unused_ok = ^{dii_insn_i, instr_bus.pkt.we, instr_bus.pkt.be, instr_bus.pkt.wdata};
`endif

endmodule

// File: tb/tb_cheriot_sim_harness.sv
// Directed bench for cheriot_sim_harness; the bench plays the core on both buses.
module tb_cheriot_sim_harness;
    import cheriot_sim_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] dii_insn_i;
    logic [31:0] dii_pc_o;
    logic        dii_ack_o;
    logic        uart_stop_sim_o;
    logic        end_sim_req_i;
    logic        end_sim_ack_o;

    cheriot_bus_if ibus ();
    cheriot_bus_if dbus ();

    cheriot_sim_harness dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dii_insn_i      (dii_insn_i),
        .dii_pc_o        (dii_pc_o),
        .dii_ack_o       (dii_ack_o),
        .uart_stop_sim_o (uart_stop_sim_o),
        .end_sim_req_i   (end_sim_req_i),
        .end_sim_ack_o   (end_sim_ack_o),
        .instr_bus       (ibus),
        .data_bus        (dbus)
    );

    always #5 clk_i = ~clk_i;

`ifdef DII_SIM_EN
    localparam logic [31:0] EXP_ACK = 32'd1;
`else
    localparam logic [31:0] EXP_ACK = 32'd0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One data-bus transaction; starts and ends just after a rising edge.
    task automatic d_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, output logic gnt, output logic rv,
                            output logic [31:0] rd);
        dbus.req = 1'b1;
        dbus.pkt = '{addr: addr, we: we, be: be, wdata: wdata};
        #1 gnt = dbus.gnt;
        @(posedge clk_i);
        #1;
        dbus.req = 1'b0;
        rv = dbus.rvalid;
        rd = dbus.rdata;
    endtask

    task automatic i_fetch(input logic [31:0] addr, input logic [31:0] insn,
                           output logic gnt, output logic ack, output logic [31:0] pc,
                           output logic rv, output logic [31:0] rd);
        ibus.req   = 1'b1;
        ibus.pkt   = '{addr: addr, we: 1'b0, be: 4'h0, wdata: 32'h0};
        dii_insn_i = insn;
        #1;
        gnt = ibus.gnt;
        ack = dii_ack_o;
        pc  = dii_pc_o;
        @(posedge clk_i);
        #1;
        ibus.req   = 1'b0;
        dii_insn_i = 32'h0;
        rv = ibus.rvalid;
        rd = ibus.rdata;
    endtask

    logic        g, a, rv;
    logic [31:0] rd, pc;

    initial begin
        rst_i = 1'b1;
        dii_insn_i = 32'h0;
        end_sim_req_i = 1'b0;
        ibus.req = 1'b0;
        ibus.pkt = '0;
        dbus.req = 1'b0;
        dbus.pkt = '0;
`ifdef DII_SIM_EN
        dut.u_instr_mem.iram[0] = 32'hFFFF_FFFF;
        dut.u_instr_mem.iram[1] = 32'hFFFF_FFFF;
`else
        dut.u_instr_mem.iram[0] = 32'h0000_0013;
        dut.u_instr_mem.iram[1] = 32'h0010_0093;
`endif
        repeat (2) tick();
        check("rst_pc", dii_pc_o, 32'h0);
        check("rst_dii_ack", 32'(dii_ack_o), 32'd0);
        check("rst_stop", 32'(uart_stop_sim_o), 32'd0);
        check("rst_end_ack", 32'(end_sim_ack_o), 32'd0);
        check("rst_irvalid", 32'(ibus.rvalid), 32'd0);
        check("rst_drvalid", 32'(dbus.rvalid), 32'd0);
        rst_i = 1'b0;
        tick();

        // Data RAM: word stores, load latency, wrap-around, byte enables
        d_access(MEM_BASE, 1'b1, 4'hF, 32'h0, g, rv, rd);
        d_access(MEM_BASE + 32'd4, 1'b1, 4'hF, 32'hCAFE_F00D, g, rv, rd);
        d_access(MEM_BASE + 32'd16, 1'b1, 4'hF, 32'hDEAD_BEEF, g, rv, rd);
        check("st_gnt", 32'(g), 32'd1);
        check("st_rvalid", 32'(rv), 32'd1);
        d_access(32'h8000_0010, 1'b0, 4'hF, 32'h0, g, rv, rd);
        check("ld_gnt", 32'(g), 32'd1);
        check("ld_rvalid", 32'(rv), 32'd1);
        check("ld_rdata", rd, 32'hDEAD_BEEF);
        tick();
        check("ld_rvalid_drop", 32'(dbus.rvalid), 32'd0);
        d_access(32'h8004_0010, 1'b0, 4'hF, 32'h0, g, rv, rd);
        check("wrap_rdata", rd, 32'hDEAD_BEEF);
        d_access(MEM_BASE, 1'b1, 4'b0010, 32'h1122_3344, g, rv, rd);
        check("be_dram0", dut.u_data_mem.dram[0], 32'h0000_3300);
        d_access(MEM_BASE, 1'b0, 4'hF, 32'h0, g, rv, rd);
        check("be_readback", rd, 32'h0000_3300);

        // Console: "Hi", read returns zero, stop is sticky, dram untouched
        d_access(CONSOLE_BASE, 1'b1, 4'hF, 32'h48, g, rv, rd);
        d_access(CONSOLE_BASE, 1'b1, 4'hF, 32'h69, g, rv, rd);
        d_access(CONSOLE_BASE, 1'b1, 4'hF, 32'h0A, g, rv, rd);
        check("con_no_stop", 32'(uart_stop_sim_o), 32'd0);
        d_access(CONSOLE_BASE, 1'b0, 4'hF, 32'h0, g, rv, rd);
        check("con_rd_rvalid", 32'(rv), 32'd1);
        check("con_rd_data", rd, 32'h0);
        dbus.req = 1'b1;
        dbus.pkt = '{addr: CONSOLE_BASE + 32'd4, we: 1'b1, be: 4'hF, wdata: 32'h5A};
        #1 check("stop_same_cycle", 32'(uart_stop_sim_o), 32'd0);
        tick();
        dbus.req = 1'b0;
        check("stop_set", 32'(uart_stop_sim_o), 32'd1);
        tick();
        check("stop_sticky", 32'(uart_stop_sim_o), 32'd1);
        check("con_dram0", dut.u_data_mem.dram[0], 32'h0000_3300);
        check("con_dram1", dut.u_data_mem.dram[1], 32'hCAFE_F00D);

        // Instruction fetches (iram, or the DII stream when enabled)
        i_fetch(MEM_BASE, 32'h0000_0013, g, a, pc, rv, rd);
        check("f0_gnt", 32'(g), 32'd1);
        check("f0_ack", 32'(a), EXP_ACK);
        check("f0_pc", pc, 32'h8000_0000);
        check("f0_rvalid", 32'(rv), 32'd1);
        check("f0_rdata", rd, 32'h0000_0013);
        i_fetch(MEM_BASE + 32'd4, 32'h0010_0093, g, a, pc, rv, rd);
        check("f1_ack", 32'(a), EXP_ACK);
        check("f1_pc", pc, 32'h8000_0004);
        check("f1_rdata", rd, 32'h0010_0093);
        tick();
        check("pc_hold", dii_pc_o, 32'h8000_0004);
        check("ack_idle", 32'(dii_ack_o), 32'd0);
        check("irvalid_drop", 32'(ibus.rvalid), 32'd0);
`ifdef DII_SIM_EN
        check("dii_nop", ibus.rdata, DII_NOP);
`endif

        // End-sim with a load in flight
        dbus.req = 1'b1;
        dbus.pkt = '{addr: MEM_BASE + 32'd16, we: 1'b0, be: 4'hF, wdata: 32'h0};
        #1 check("es_first_gnt", 32'(dbus.gnt), 32'd1);
        tick();
        end_sim_req_i = 1'b1;
        ibus.req = 1'b1;
        ibus.pkt = '{addr: MEM_BASE, we: 1'b0, be: 4'h0, wdata: 32'h0};
        #1;
        check("es_dgnt_block", 32'(dbus.gnt), 32'd0);
        check("es_ignt_block", 32'(ibus.gnt), 32'd0);
        check("es_rvalid", 32'(dbus.rvalid), 32'd1);
        check("es_ack_early", 32'(end_sim_ack_o), 32'd0);
        tick();
        check("es_ack", 32'(end_sim_ack_o), 32'd1);
        check("es_no_new_rvalid", 32'(dbus.rvalid), 32'd0);
        dbus.req = 1'b0;
        ibus.req = 1'b0;
        end_sim_req_i = 1'b0;
        tick();
        check("es_ack_hold", 32'(end_sim_ack_o), 32'd1);

        // Asynchronous reset with a fetch response pending
        ibus.req = 1'b1;
        ibus.pkt = '{addr: MEM_BASE + 32'd4, we: 1'b0, be: 4'h0, wdata: 32'h0};
        #1 check("rr_gnt", 32'(ibus.gnt), 32'd1);
        tick();
        ibus.req = 1'b0;
        check("rr_pre_rvalid", 32'(ibus.rvalid), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rr_irvalid", 32'(ibus.rvalid), 32'd0);
        check("rr_end_ack", 32'(end_sim_ack_o), 32'd0);
        check("rr_stop", 32'(uart_stop_sim_o), 32'd0);
        check("rr_pc", dii_pc_o, 32'h0);
        check("rr_dii_ack", 32'(dii_ack_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        check("rr_after_irvalid", 32'(ibus.rvalid), 32'd0);
        check("rr_after_drvalid", 32'(dbus.rvalid), 32'd0);

        // End-sim from idle: ack one cycle after the request
        end_sim_req_i = 1'b1;
        #1 check("idle_ack_early", 32'(end_sim_ack_o), 32'd0);
        tick();
        check("idle_ack", 32'(end_sim_ack_o), 32'd1);
        end_sim_req_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
